// File: rtl/mc_controller_if.sv
// ----------------------------------------------------------------------------
// mc_controller_if
//   Bundle between the multicycle control FSM and the multicycle datapath /
//   memory side. The FSM connects through "master": it reads the IR fields,
//   the ALU zero flag and the memory ready flag, and drives every datapath
//   select and enable. The datapath, or a testbench acting in its place,
//   connects through "slave".
//
//   Signals
//     op[5:0]       instr[31:26] from IR
//     funct[5:0]    instr[5:0] from IR
//     zero          ALU zero flag, valid in the same cycle
//     memready      memory finishes the current read/write this cycle
//     pcen          PC register enable
//     regwrite      register file write enable
//     alusrca       ALU A select: 0 pc, 1 latched rs
//     alusrcb[1:0]  ALU B select: 00 reg, 01 const 4, 10 signimm, 11 signimm<<2
//     pcsrc[1:0]    next-PC select: 00 aluresult, 01 aluout, 10 jump target
//     alucont[2:0]  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
//     memtoreg      writeback data: 1 readdata, 0 aluout
//     regdst        destination register: 1 rd, 0 rt
//     iord          memory address: 0 pc, 1 aluout
//     memread       memory read request
//     memwrite      memory write request
//     irwrite       IR load enable
//     illegal       one-cycle pulse on an unsupported op/funct
//     state_o[3:0]  current FSM state (debug)
// ----------------------------------------------------------------------------
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;

    logic       pcen;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucont;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  op, funct, zero, memready,
        output pcen, regwrite, alusrca, alusrcb, pcsrc, alucont,
               memtoreg, regdst, iord, memread, memwrite, irwrite,
               illegal, state_o
    );

    modport slave (
        output op, funct, zero, memready,
        input  pcen, regwrite, alusrca, alusrcb, pcsrc, alucont,
               memtoreg, regdst, iord, memread, memwrite, irwrite,
               illegal, state_o
    );
endinterface

// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller
//   Control FSM for a multicycle MIPS datapath. Decodes the IR opcode/funct,
//   sequences fetch, decode, execute, memory and writeback, and drives every
//   datapath select/enable plus the memory request lines. Memory accesses
//   stall on the memready handshake.
//
//   Ports
//     clk    in  clock, all state on the rising edge
//     reset  in  asynchronous, active-high; forces FETCH
//     bus    mc_controller_if.master (IR fields, zero, memready in;
//            datapath controls, illegal pulse and state_o out)
//
//   Build option
//     MC_CTRL_BNE_EN  when defined, op 000101 (bne) is accepted and shares
//                     the beq execute state with the zero test inverted.
//                     When undefined, 000101 is reported as illegal.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   FETCH   | read instruction at pc, pc+4 -> pc, load IR once memready
//   DECODE  | branch target into aluout, dispatch on op
//   MEMADR  | rs + signimm effective address for lw/sw
//   MEMRD   | data read at aluout, wait for memready
//   MEMWB   | readdata -> rt
//   MEMWR   | data write at aluout, wait for memready
//   RTEX    | rs op rt, ALU op from funct
//   RTWB    | aluout -> rd
//   BEQEX   | rs - rt compare, branch to aluout on condition
//   ADDIEX  | rs + signimm
//   ADDIWB  | aluout -> rt
//   JEX     | jump target -> pc
// ----------------------------------------------------------------------------
module mc_controller (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t     state;
    state_t     state_next;

    logic       funct_legal;
    logic [2:0] funct_alu;

    logic       pcen;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucont;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       illegal;

    // Reset is applied asynchronously so that every output falls back to
    // its FETCH value (memwrite/regwrite low) in the cycle reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // R-type ALU operation; shared by RTEX and RTWB so the result stays
    // stable across the writeback cycle.
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (bus.funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        pcen       = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PC_ALURES;
        alucont    = ALU_ADD;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                // PC and IR only move once the instruction word is present.
                irwrite = bus.memready;
                pcen    = bus.memready;
                state_next = bus.memready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Precompute the branch target while the register file reads.
                alusrcb = SRCB_SHIMM;
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTEX;
                    OP_BEQ:       state_next = S_BEQEX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_next = S_BEQEX;
`endif
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                if (bus.op == OP_LW) begin
                    state_next = S_MEMRD;
                end else if (bus.op == OP_SW) begin
                    state_next = S_MEMWR;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                state_next = bus.memready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_next = S_FETCH;
            end

            S_MEMWR: begin
                // The write request stays up for every stall cycle.
                iord     = 1'b1;
                memwrite = 1'b1;
                state_next = bus.memready ? S_FETCH : S_MEMWR;
            end

            S_RTEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_REG;
                if (funct_legal) begin
                    alucont    = funct_alu;
                    state_next = S_RTWB;
                end else begin
                    illegal    = 1'b1;
                    state_next = S_FETCH;
                end
            end

            S_RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                alucont  = funct_alu;
                state_next = S_FETCH;
            end

            S_BEQEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_REG;
                alucont = ALU_SUB;
                pcsrc   = PC_ALUOUT;
`ifdef MC_CTRL_BNE_EN
                // beq and bne share this state; the op still held in IR
                // selects the sense of the zero test.
                pcen = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
`else
                pcen = bus.zero;
`endif
                state_next = S_FETCH;
            end

            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_next = S_ADDIWB;
            end

            S_ADDIWB: begin
                regwrite = 1'b1;
                state_next = S_FETCH;
            end

            S_JEX: begin
                pcsrc = PC_JUMP;
                pcen  = 1'b1;
                state_next = S_FETCH;
            end

            // Unused encodings drive all-inactive outputs and recover to FETCH.
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign bus.pcen     = pcen;
    assign bus.regwrite = regwrite;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsrc    = pcsrc;
    assign bus.alucont  = alucont;
    assign bus.memtoreg = memtoreg;
    assign bus.regdst   = regdst;
    assign bus.iord     = iord;
    assign bus.memread  = memread;
    assign bus.memwrite = memwrite;
    assign bus.irwrite  = irwrite;
    assign bus.illegal  = illegal;
    assign bus.state_o  = state;

endmodule

// File: tb/tb_mc_controller.sv
// ----------------------------------------------------------------------------
// tb_mc_controller
//   Directed and randomized instruction streams for mc_controller. For each
//   instruction the bench builds the list of states it expects to visit
//   (including memory stall cycles) and checks state_o plus every control
//   output in every cycle against a per-state output table.
// ----------------------------------------------------------------------------
module tb_mc_controller;

    localparam int FETCH  = 0;
    localparam int DECODE = 1;
    localparam int MEMADR = 2;
    localparam int MEMRD  = 3;
    localparam int MEMWB  = 4;
    localparam int MEMWR  = 5;
    localparam int RTEX   = 6;
    localparam int RTWB   = 7;
    localparam int BEQEX  = 8;
    localparam int ADDIEX = 9;
    localparam int ADDIWB = 10;
    localparam int JEX    = 11;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RTY  = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    typedef struct packed {
        logic       pcen;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucont;
        logic       memtoreg;
        logic       regdst;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       illegal;
    } ctrl_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic bit bne_enabled();
`ifdef MC_CTRL_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit op_supported(input logic [5:0] op);
        return (op == LW) || (op == SW) || (op == RTY) || (op == BEQ) ||
               (op == ADDI) || (op == JMP) || (bne_enabled() && op == BNE);
    endfunction

    // {legal, alucont}
    function automatic logic [3:0] rtype_alu(input logic [5:0] funct);
        case (funct)
            6'b100000: return {1'b1, 3'b010};
            6'b100010: return {1'b1, 3'b110};
            6'b100100: return {1'b1, 3'b000};
            6'b100101: return {1'b1, 3'b001};
            6'b101010: return {1'b1, 3'b111};
            default:   return {1'b0, 3'b010};
        endcase
    endfunction

    function automatic ctrl_t expect_ctrl(input int st, input logic [5:0] op,
                                          input logic [5:0] funct,
                                          input logic zero, input logic mr);
        ctrl_t      c;
        logic [3:0] ra;
        c         = '0;
        c.alucont = 3'b010;
        ra        = rtype_alu(funct);
        case (st)
            FETCH:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcen = mr; end
            DECODE: begin c.alusrcb = 2'b11; c.illegal = !op_supported(op); end
            MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            MEMRD:  begin c.iord = 1; c.memread = 1; end
            MEMWB:  begin c.regwrite = 1; c.memtoreg = 1; end
            MEMWR:  begin c.iord = 1; c.memwrite = 1; end
            RTEX:   begin c.alusrca = 1; c.alucont = ra[2:0]; c.illegal = !ra[3]; end
            RTWB:   begin c.regwrite = 1; c.regdst = 1; c.alucont = ra[2:0]; end
            BEQEX:  begin
                c.alusrca = 1; c.alucont = 3'b110; c.pcsrc = 2'b01;
                c.pcen = (op == BNE) ? !zero : zero;
            end
            ADDIEX: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            ADDIWB: begin c.regwrite = 1; end
            JEX:    begin c.pcsrc = 2'b10; c.pcen = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t observed_ctrl();
        ctrl_t c;
        c.pcen     = bus.pcen;
        c.regwrite = bus.regwrite;
        c.alusrca  = bus.alusrca;
        c.alusrcb  = bus.alusrcb;
        c.pcsrc    = bus.pcsrc;
        c.alucont  = bus.alucont;
        c.memtoreg = bus.memtoreg;
        c.regdst   = bus.regdst;
        c.iord     = bus.iord;
        c.memread  = bus.memread;
        c.memwrite = bus.memwrite;
        c.irwrite  = bus.irwrite;
        c.illegal  = bus.illegal;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs shortly after the edge, then check.
    task automatic step(input string name, input int st, input logic [5:0] op,
                        input logic [5:0] funct, input logic zero, input logic mr);
        @(posedge clk);
        #2;
        bus.op       = op;
        bus.funct    = funct;
        bus.zero     = zero;
        bus.memready = mr;
        #2;
        check($sformatf("%s state", name), 32'(bus.state_o), 32'(st));
        check($sformatf("%s ctrl(st%0d)", name, st), 32'(observed_ctrl()),
              32'(expect_ctrl(st, op, funct, zero, mr)));
    endtask

    // Expected state walk for one instruction, fw fetch stalls and mw data stalls.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input int fw, input int mw);
        int   sq[$];
        logic mq[$];
        logic [3:0] ra;
        ra = rtype_alu(funct);
        for (int i = 0; i < fw; i++) begin sq.push_back(FETCH); mq.push_back(1'b0); end
        sq.push_back(FETCH);  mq.push_back(1'b1);
        sq.push_back(DECODE); mq.push_back(1'($urandom_range(0, 1)));
        if (op == LW) begin
            sq.push_back(MEMADR); mq.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < mw; i++) begin sq.push_back(MEMRD); mq.push_back(1'b0); end
            sq.push_back(MEMRD);  mq.push_back(1'b1);
            sq.push_back(MEMWB);  mq.push_back(1'($urandom_range(0, 1)));
        end else if (op == SW) begin
            sq.push_back(MEMADR); mq.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < mw; i++) begin sq.push_back(MEMWR); mq.push_back(1'b0); end
            sq.push_back(MEMWR);  mq.push_back(1'b1);
        end else if (op == RTY) begin
            sq.push_back(RTEX); mq.push_back(1'($urandom_range(0, 1)));
            if (ra[3]) begin sq.push_back(RTWB); mq.push_back(1'($urandom_range(0, 1))); end
        end else if (op == BEQ || (op == BNE && bne_enabled())) begin
            sq.push_back(BEQEX); mq.push_back(1'($urandom_range(0, 1)));
        end else if (op == ADDI) begin
            sq.push_back(ADDIEX); mq.push_back(1'($urandom_range(0, 1)));
            sq.push_back(ADDIWB); mq.push_back(1'($urandom_range(0, 1)));
        end else if (op == JMP) begin
            sq.push_back(JEX); mq.push_back(1'($urandom_range(0, 1)));
        end
        foreach (sq[i]) step($sformatf("%s c%0d", name, i), sq[i], op, funct, zero, mq[i]);
    endtask

    initial begin
        logic [5:0] op_pool [7];
        logic [5:0] fn_pool [6];
        logic [5:0] rop;
        logic [5:0] rfn;
        tests = 0;
        fails = 0;
        op_pool = '{LW, SW, RTY, BEQ, BNE, ADDI, JMP};
        fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

        reset        = 1'b1;
        bus.op       = 6'd0;
        bus.funct    = 6'd0;
        bus.zero     = 1'b0;
        bus.memready = 1'b0;
        #3;
        check("reset state", 32'(bus.state_o), 32'(FETCH));
        check("reset ctrl", 32'(observed_ctrl()), 32'(expect_ctrl(FETCH, 6'd0, 6'd0, 1'b0, 1'b0)));
        #5;
        reset = 1'b0;

        run_instr("lw", LW, 6'd0, 1'b0, 0, 0);
        run_instr("lw_stall", LW, 6'd0, 1'b1, 2, 1);
        run_instr("sw_wait3", SW, 6'd0, 1'b0, 0, 3);
        run_instr("r_slt", RTY, 6'b101010, 1'b0, 0, 0);
        run_instr("r_bad", RTY, 6'b000111, 1'b0, 0, 0);
        run_instr("beq_taken", BEQ, 6'd0, 1'b1, 0, 0);
        run_instr("beq_not", BEQ, 6'd0, 1'b0, 0, 0);
        run_instr("j", JMP, 6'd0, 1'b0, 0, 0);
        run_instr("addi", ADDI, 6'd0, 1'b0, 1, 0);
        run_instr("op000101", BNE, 6'd0, 1'b0, 0, 0);
        run_instr("bogus_op", 6'b111111, 6'd0, 1'b0, 0, 0);

        // Reset in the middle of a stalled store.
        step("rst_mid f", FETCH, SW, 6'd0, 1'b0, 1'b1);
        step("rst_mid d", DECODE, SW, 6'd0, 1'b0, 1'b0);
        step("rst_mid a", MEMADR, SW, 6'd0, 1'b0, 1'b0);
        step("rst_mid w", MEMWR, SW, 6'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid state", 32'(bus.state_o), 32'(FETCH));
        check("rst_mid memwrite", 32'(bus.memwrite), 32'd0);
        check("rst_mid regwrite", 32'(bus.regwrite), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check("rst_rel ctrl", 32'(observed_ctrl()), 32'(expect_ctrl(FETCH, SW, 6'd0, 1'b0, 1'b0)));
        check("rst_rel alusrcb", 32'(bus.alusrcb), 32'd1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) rop = 6'($urandom_range(0, 63));
            else rop = op_pool[$urandom_range(0, 6)];
            if ($urandom_range(0, 5) == 0) rfn = 6'($urandom_range(0, 63));
            else rfn = fn_pool[$urandom_range(0, 5)];
            run_instr($sformatf("rnd%0d op%02h fn%02h", n, rop, rfn), rop, rfn,
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
